// File: rtl/floppy_pkg.sv
// -----------------------------------------------------------------------------
// floppy_pkg
// Shared definitions for the pipe scroller playfield:
//   GRID      - playfield width and height (columns x rows)
//   BIRD_COL  - column the bird occupies; collisions and scoring look here
//   LFSR_SEED - reset value of the 4-bit pipe-offset LFSR (must be non-zero)
//   state_t   - game FSM states
//   field_t   - 16x16 pixel plane, indexed [column][row]
//   pipe_column() - builds one pipe column from the LFSR value
// -----------------------------------------------------------------------------
package floppy_pkg;

   localparam int GRID     = 16;
   localparam int BIRD_COL = 4;

   localparam logic [3:0] LFSR_SEED = 4'b1001;

   typedef enum logic [1:0] {
      ST_READY   = 2'd0,
      ST_RUN     = 2'd1,
      ST_CRASHED = 2'd2
   } state_t;

   typedef logic [GRID-1:0][GRID-1:0] field_t;

   // A pipe column is solid except for a gap of 'gap' rows starting at 'off'.
   // The LFSR value is folded back into the legal offset range so the gap
   // never runs past the top row.
   function automatic logic [GRID-1:0] pipe_column(input logic [3:0] v, input int gap);
      int              span;
      int              off;
      logic [GRID-1:0] col;
      span = GRID - gap;
      off  = (int'(v) <= span) ? int'(v) : int'(v) - span;
      for (int r = 0; r < GRID; r++) begin
         col[r] = !((r >= off) && (r < off + gap));
      end
      return col;
   endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// -----------------------------------------------------------------------------
// pipe_lfsr
// 4-bit Fibonacci LFSR, polynomial x^4 + x^3 + 1, maximal length (15 states),
// so it never reaches zero from the non-zero seed.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset, loads LFSR_SEED
//   en    - advance one step this cycle
//   q     - current LFSR value
// -----------------------------------------------------------------------------
module pipe_lfsr
   import floppy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic [3:0] q
);

   logic [3:0] q_q;
   logic [3:0] q_d;

   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = {q_q[2:0], q_q[3] ^ q_q[2]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= LFSR_SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/pipe_scroller.sv
// -----------------------------------------------------------------------------
// pipe_scroller
// Scrolls a 16x16 field of pipes right-to-left, detects bird/pipe collisions
// and counts pipes passed.
// Parameters:
//   SCROLL_DIV   - tick pulses per one-column scroll (1..255)
//   PIPE_SPACING - columns from one pipe to the next, pipe column included (2..16)
//   GAP          - open rows per pipe (2..12)
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   tick  - single-cycle game-rate enable
//   run   - game active; 0 freezes scrolling but keeps the field
//   bird  - bird occupancy of column BIRD_COL, bit r = row r
//   field - pipe pixels, field[c][r]
//   hit   - collision has occurred (game over)
//   score - pipes passed, saturating at 255
// Build option:
//   SCORE_EN - when defined the score counter is built; otherwise score = 0.
// -----------------------------------------------------------------------------
module pipe_scroller
   import floppy_pkg::*;
#(
   parameter int SCROLL_DIV   = 8,
   parameter int PIPE_SPACING = 6,
   parameter int GAP          = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tick,
   input  logic                        run,
   input  logic [15:0]                 bird,
   output logic [15:0][15:0]           field,
   output logic                        hit,
   output logic [7:0]                  score
);

   localparam logic [7:0] DIV_LAST = 8'(SCROLL_DIV - 1);
   localparam logic [3:0] SP_LAST  = 4'(PIPE_SPACING - 1);

   state_t     state_q, state_d;
   field_t     field_q, field_d;
   logic [7:0] div_q, div_d;
   logic [3:0] sp_q, sp_d;
   logic [3:0] lfsr_q;
   logic       collide;
   logic       scroll;

   pipe_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (scroll),
      .q     (lfsr_q)
   );

   // Collision looks at the registered field, so it also fires while run=0.
   // A collision always beats a scroll due in the same cycle.
   always_comb begin
      collide = (state_q == ST_RUN) && (|(field_q[BIRD_COL] & bird));
      scroll  = (state_q == ST_RUN) && !collide && tick && run && (div_q == DIV_LAST);
   end

   always_comb begin
      state_d = state_q;
      field_d = field_q;
      div_d   = div_q;
      sp_d    = sp_q;
      case (state_q)
         ST_READY: begin
            field_d = '0;
            if (tick && run) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (collide) begin
               state_d = ST_CRASHED;
            end else if (tick && run) begin
               if (scroll) begin
                  div_d = 8'd0;
                  for (int c = 0; c < GRID - 1; c++) begin
                     field_d[c] = field_q[c+1];
                  end
                  field_d[GRID-1] = (sp_q == 4'd0) ? pipe_column(lfsr_q, GAP) : '0;
                  sp_d            = (sp_q == 4'd0) ? SP_LAST : sp_q - 4'd1;
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
         end
         ST_CRASHED: begin
            // Everything frozen until reset.
         end
         default: begin
            state_d = ST_READY;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_READY;
         field_q <= '0;
         div_q   <= 8'd0;
         sp_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         div_q   <= div_d;
         sp_q    <= sp_d;
      end
   end

`ifdef SCORE_EN
   logic [7:0] score_q, score_d;

   // A pipe is counted when it is shifted out of the bird column intact.
   always_comb begin
      score_d = score_q;
      if (scroll && (|field_q[BIRD_COL]) && (score_q != 8'hFF)) begin
         score_d = score_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score_q <= 8'd0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;
`else
   assign score = 8'd0;
`endif

   assign field = field_q;
   assign hit   = (state_q == ST_CRASHED);

endmodule

// File: tb/tb_pipe_scroller.sv
// -----------------------------------------------------------------------------
// tb_pipe_scroller
// Directed bench for pipe_scroller with SCROLL_DIV=2 and default spacing/gap.
// Pipes enter on scrolls 1, 7, 13, 19, 25 with gap offsets 9, 11, 1, 1, ...
// from the LFSR sequence 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, ...
// Pipe patterns: off 9 -> E1FF, off 11 -> 87FF, off 1 -> FFE1.
// -----------------------------------------------------------------------------
module tb_pipe_scroller;

   logic              clk = 1'b0;
   logic              reset;
   logic              tick;
   logic              run;
   logic [15:0]       bird;
   logic [15:0][15:0] field;
   logic              hit;
   logic [7:0]        score;

   logic [15:0][15:0] exp_f;
   int                checks   = 0;
   int                failures = 0;
   int                n_scroll = 0;

`ifdef SCORE_EN
   localparam bit SCORE_ON = 1'b1;
`else
   localparam bit SCORE_ON = 1'b0;
`endif

   pipe_scroller #(
      .SCROLL_DIV   (2),
      .PIPE_SPACING (6),
      .GAP          (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .run   (run),
      .bird  (bird),
      .field (field),
      .hit   (hit),
      .score (score)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_score(input int n);
      return SCORE_ON ? 8'(n) : 8'd0;
   endfunction

   // One clock with the given tick value; returns 1 time unit after the edge.
   task automatic cycle(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   // SCROLL_DIV=2: two ticks per scroll starting from a zero divider.
   task automatic scroll_once();
      cycle(1'b1);
      cycle(1'b1);
      n_scroll++;
      $display("scroll %0d: col15=%h col4=%h hit=%b score=%0d", n_scroll, field[15], field[4], hit, score);
   endtask

   task automatic test_reset();
      reset = 1'b1; tick = 1'b0; run = 1'b0; bird = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (field !== '0) begin failures++; $display("FAIL reset_field: got %h expected 0", field); end
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b expected 0", hit); end
      checks++; if (score !== 8'd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", score); end
      // tick without run keeps READY; run without tick too
      cycle(1'b1);
      run = 1'b1;
      cycle(1'b0);
      checks++; if (field !== '0) begin failures++; $display("FAIL ready_field: got %h expected 0", field); end
      // entering RUN does not scroll
      cycle(1'b1);
      checks++; if (field !== '0) begin failures++; $display("FAIL enter_run_field: got %h expected 0", field); end
      $display("reset/ready done");
   endtask

   task automatic test_first_pipe();
      cycle(1'b1);
      checks++; if (field !== '0) begin failures++; $display("FAIL div_hold: got %h expected 0", field); end
      cycle(1'b1);
      n_scroll++;
      exp_f = '0; exp_f[15] = 16'hE1FF;
      checks++; if (field !== exp_f) begin failures++; $display("FAIL first_pipe: got %h expected %h", field, exp_f); end
      $display("scroll %0d: col15=%h", n_scroll, field[15]);
   endtask

   task automatic test_pass_gap();
      bird = 16'h0200;
      repeat (11) scroll_once();
      exp_f = '0; exp_f[4] = 16'hE1FF; exp_f[10] = 16'h87FF;
      checks++; if (field !== exp_f) begin failures++; $display("FAIL pipe_at_bird: got %h expected %h", field, exp_f); end
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL gap_hit: got %b expected 0", hit); end
      checks++; if (score !== exp_score(0)) begin failures++; $display("FAIL score_before_pass: got %0d expected %0d", score, exp_score(0)); end
      scroll_once();
      exp_f = '0; exp_f[3] = 16'hE1FF; exp_f[9] = 16'h87FF; exp_f[15] = 16'hFFE1;
      checks++; if (field !== exp_f) begin failures++; $display("FAIL pass_field: got %h expected %h", field, exp_f); end
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL pass_hit: got %b expected 0", hit); end
      checks++; if (score !== exp_score(1)) begin failures++; $display("FAIL pass_score: got %0d expected %0d", score, exp_score(1)); end
   endtask

   task automatic test_run_pause();
      bird = 16'h0;
      cycle(1'b1);
      run = 1'b0;
      repeat (20) cycle(1'b1);
      $display("pause: 20 ticks with run=0");
      checks++; if (field !== exp_f) begin failures++; $display("FAIL pause_field: got %h expected %h", field, exp_f); end
      checks++; if (score !== exp_score(1)) begin failures++; $display("FAIL pause_score: got %0d expected %0d", score, exp_score(1)); end
      run = 1'b1;
      cycle(1'b1);
      n_scroll++;
      exp_f = '0; exp_f[2] = 16'hE1FF; exp_f[8] = 16'h87FF; exp_f[14] = 16'hFFE1;
      checks++; if (field !== exp_f) begin failures++; $display("FAIL resume_field: got %h expected %h", field, exp_f); end
      $display("scroll %0d: resumed", n_scroll);
   endtask

   task automatic test_lfsr_wrap();
      repeat (5) scroll_once();
      exp_f = '0; exp_f[3] = 16'h87FF; exp_f[9] = 16'hFFE1; exp_f[15] = 16'hFFE1;
      checks++; if (field !== exp_f) begin failures++; $display("FAIL lfsr_fold_field: got %h expected %h", field, exp_f); end
      checks++; if (score !== exp_score(2)) begin failures++; $display("FAIL second_pass_score: got %0d expected %0d", score, exp_score(2)); end
   endtask

   task automatic test_crash();
      repeat (5) scroll_once();
      exp_f = '0; exp_f[4] = 16'hFFE1; exp_f[10] = 16'hFFE1;
      checks++; if (field !== exp_f) begin failures++; $display("FAIL pre_crash_field: got %h expected %h", field, exp_f); end
      cycle(1'b1);
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL pre_crash_hit: got %b expected 0", hit); end
      // scroll due this cycle, bird in solid row 0: crash must win
      bird = 16'h0001;
      cycle(1'b1);
      $display("crash cycle: hit=%b col4=%h", hit, field[4]);
      checks++; if (hit !== 1'b1) begin failures++; $display("FAIL crash_hit: got %b expected 1", hit); end
      checks++; if (field !== exp_f) begin failures++; $display("FAIL crash_no_shift: got %h expected %h", field, exp_f); end
      bird = 16'h0;
      repeat (6) cycle(1'b1);
      checks++; if (field !== exp_f) begin failures++; $display("FAIL crashed_freeze: got %h expected %h", field, exp_f); end
      checks++; if (hit !== 1'b1) begin failures++; $display("FAIL crashed_hold_hit: got %b expected 1", hit); end
      checks++; if (score !== exp_score(2)) begin failures++; $display("FAIL crashed_score: got %0d expected %0d", score, exp_score(2)); end
   endtask

   task automatic test_async_reset();
      #2;
      reset = 1'b1;
      #1;
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL async_hit: got %b expected 0", hit); end
      checks++; if (field !== '0) begin failures++; $display("FAIL async_field: got %h expected 0", field); end
      checks++; if (score !== 8'd0) begin failures++; $display("FAIL async_score: got %0d expected 0", score); end
      #1;
      reset = 1'b0;
      $display("async reset pulse done");
      cycle(1'b1);
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rerun_hit: got %b expected 0", hit); end
      cycle(1'b1);
      cycle(1'b1);
      exp_f = '0; exp_f[15] = 16'hE1FF;
      checks++; if (field !== exp_f) begin failures++; $display("FAIL rerun_first_pipe: got %h expected %h", field, exp_f); end
      $display("rerun scroll: col15=%h", field[15]);
   endtask

   initial begin
      test_reset();
      test_first_pipe();
      test_pass_gap();
      test_run_pause();
      test_lfsr_wrap();
      test_crash();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
